// File: rtl/multi_edge_detector.sv
// Per-channel synchronizer -> debounce -> edge detector with sticky W1C pending flags and an OR'd irq.
// Latency: SYNC_STAGES+DEBOUNCE clocks from input change to level/pulse; no backpressure, events are never stalled.
module multi_edge_detector #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   signal_in,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   pulse,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] level_d;
  logic [N_CH-1:0] pulse_d;
  logic [N_CH-1:0] pending_d;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= signal_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A count of DEBOUNCE consecutive disagreeing samples moves the level;
  // any agreeing sample restarts the count.
  always_comb begin
    level_d = level;
    pulse_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s[i];
          pulse_d[i] = s[i] ? mode[2*i] : mode[2*i+1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    pending_d = (pending & ~clr) | pulse_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= '0;
      pulse   <= '0;
      pending <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      level   <= level_d;
      pulse   <= pulse_d;
      pending <= pending_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios plus random traffic, every cycle scored
// against a sample-history reference model through an expected-value queue.
module tb_multi_edge_detector;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DB = 4;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
    logic [N-1:0] pnd;
    logic         irq;
  } obs_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   signal_in = '0;
  logic [2*N-1:0] mode = '0;
  logic [N-1:0]   clr = '0;
  logic [N-1:0]   level, pulse, pending;
  logic           irq;

  int vectors = 0;
  int miscompares = 0;

  obs_t         exp_q[$];
  logic [N-1:0] smp[$];
  logic [N-1:0] m_lvl;
  logic [N-1:0] m_pend;

  multi_edge_detector #(.N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .mode(mode), .clr(clr),
    .level(level), .pulse(pulse), .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: raw samples are kept newest-first; the debounce logic sees the
  // sample taken SS edges ago, and the level moves when the last DB seen samples
  // all agree with each other and differ from the level.
  function automatic void model_reset();
    smp.delete();
    for (int j = 0; j < SS + DB; j++) smp.push_back('0);
    m_lvl  = '0;
    m_pend = '0;
  endfunction

  function automatic obs_t model_edge(input logic [N-1:0] in, input logic [2*N-1:0] md,
                                      input logic [N-1:0] cl);
    logic [N-1:0] ev;
    logic         x, stable;
    obs_t         o;
    smp.push_front(in);
    while (smp.size() > SS + DB) void'(smp.pop_back());
    ev = '0;
    for (int ch = 0; ch < N; ch++) begin
      x = smp[SS][ch];
      stable = 1'b1;
      for (int j = SS; j < SS + DB; j++) if (smp[j][ch] != x) stable = 1'b0;
      if (stable && x != m_lvl[ch]) begin
        m_lvl[ch] = x;
        ev[ch] = x ? md[2*ch] : md[2*ch+1];
      end
    end
    m_pend = (m_pend & ~cl) | ev;
    o.lvl = m_lvl;
    o.pls = ev;
    o.pnd = m_pend;
    o.irq = |m_pend;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) exp_q.push_back(model_edge(signal_in, mode, clr));
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      chk("scoreboard", 32'({level, pulse, pending, irq}), 32'(e));
    end
  end

  // Asserts reset away from any clock edge, holds it over one edge, releases mid-cycle.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #2;
    chk({name, "_async"}, 32'({level, pulse, pending, irq}), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_held"}, 32'({level, pulse, pending, irq}), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_pulse(input int ch, input int expn, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!pulse[ch] && n < 20);
    chk(name, 32'(n), 32'(expn));
  endtask

  task automatic settle();
    signal_in = '0;
    clr = '1;
    repeat (8) step();
    clr = '0;
    step();
  endtask

  initial begin
    int cnt_p[N];
    int lvl_toggles;
    logic [N-1:0] prev_lvl;

    // T1: input already high at release, all channels rising
    signal_in = 4'hF;
    mode = 8'h55;
    #3;
    do_reset("t1_reset");
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) chk("t1_before_edge6", 32'({level, pulse}), 32'd0);
      if (k == 6) chk("t1_edge6", 32'({level, pulse}), 32'hFF);
      if (k == 7) chk("t1_one_cycle", 32'(pulse), 32'd0);
    end

    // T2: rising-only on ch0
    settle();
    signal_in = 4'h1;
    wait_pulse(0, 6, "t2_latency");
    chk("t2_pending_irq", 32'({pending[0], irq}), 32'b11);
    repeat (4) step();
    signal_in = 4'h0;
    cnt_p[0] = 0;
    repeat (10) begin
      step();
      cnt_p[0] += int'(pulse[0]);
    end
    chk("t2_no_fall_pulse", 32'(cnt_p[0]), 32'd0);
    chk("t2_level_low", 32'(level[0]), 32'd0);

    // T3: glitch rejection on ch1
    settle();
    cnt_p[1] = 0;
    signal_in = 4'h2;
    repeat (3) step();
    signal_in = 4'h0;
    repeat (10) begin
      step();
      cnt_p[1] += int'(pulse[1]);
    end
    chk("t3_glitch_rejected", 32'({cnt_p[1][3:0], level[1], pending[1]}), 32'd0);
    signal_in = 4'h2;
    repeat (4) step();
    signal_in = 4'h0;
    repeat (10) begin
      step();
      cnt_p[1] += int'(pulse[1]);
    end
    chk("t3_four_cycles_pulse", 32'(cnt_p[1]), 32'd1);

    // T4: ch0 both, ch1 fall, ch2 off, ch3 rise on a 20-clock square wave
    signal_in = '0;
    do_reset("t4_reset");
    mode = 8'h4B;
    for (int c = 0; c < N; c++) cnt_p[c] = 0;
    lvl_toggles = 0;
    prev_lvl = level;
    for (int cyc = 0; cyc < 68; cyc++) begin
      signal_in = (cyc < 60 && (cyc % 20) < 10) ? 4'hF : 4'h0;
      step();
      for (int c = 0; c < N; c++) cnt_p[c] += int'(pulse[c]);
      if (level[2] != prev_lvl[2]) lvl_toggles++;
      prev_lvl = level;
    end
    chk("t4_ch0_both", 32'(cnt_p[0]), 32'd6);
    chk("t4_ch1_fall", 32'(cnt_p[1]), 32'd3);
    chk("t4_ch2_off", 32'(cnt_p[2]), 32'd0);
    chk("t4_ch3_rise", 32'(cnt_p[3]), 32'd3);
    chk("t4_ch2_level_toggles", 32'(lvl_toggles), 32'd6);

    // T6: reset two cycles into a debounce count, with pending flags set
    mode = 8'h55;
    signal_in = 4'h4;
    repeat (4) step();
    chk("t6_pending_before", 32'(irq), 32'd1);
    do_reset("t6_reset");
    wait_pulse(2, 6, "t6_full_latency");

    // T5: clear racing the set, then clear one cycle later
    settle();
    signal_in = 4'h1;
    repeat (5) step();
    clr = 4'h1;
    step();
    chk("t5_set_wins", 32'({pulse[0], pending[0]}), 32'b11);
    step();
    chk("t5_cleared", 32'({pending[0], irq}), 32'b00);
    clr = '0;

    // Random traffic with one mid-stream reset
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(5) == 0) signal_in[c] = ~signal_in[c];
      if (cyc % 50 == 0) mode = 8'($urandom);
      clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
      if (cyc == 200) do_reset("rand_reset");
      step();
    end

    clr = '0;
    repeat (2) step();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
